// File: rtl/rs_encoder_204_188_if.sv
// Byte-stream bus of the RS(204,188) encoder: input handshake and registered codeword output.
interface rs_encoder_204_188_if;
   // A byte moves on a rising Clk edge only when in_valid and in_ready are both 1; the
   // source may hold in_valid as long as it likes and nothing is consumed while in_ready=0.
   logic [7:0] in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out;
   logic       out_valid;
   logic       out_sop;
   logic       out_eop;

   modport slave (
      input  in, in_valid,
      output in_ready, out, out_valid, out_sop, out_eop
   );

   modport master (
      output in, in_valid,
      input  in_ready, out, out_valid, out_sop, out_eop
   );
endinterface

// File: rtl/rs_encoder_204_188.sv
// Systematic shortened RS(204,188) encoder over GF(2^8)/0x11D, 16-stage LFSR, 1-cycle latency.
// Optional RS_ENC_PKT_CNT_EN adds a 16-bit count of completed codewords on pkt_cnt.
module rs_encoder_204_188 #(
   parameter int N_DATA = 188
) (
   input  logic                  Clk,
   input  logic                  Reset,
   rs_encoder_204_188_if.slave   enc_if,
`ifdef RS_ENC_PKT_CNT_EN
   output logic [15:0]           pkt_cnt,
`endif
   output logic [1:0]            dbg_state_o
);

   localparam int N_PAR = 16;
   localparam logic [7:0] LAST_DATA = 8'(N_DATA - 1);
   localparam logic [7:0] LAST_PAR  = 8'(N_DATA + N_PAR - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   // Coefficient idx of g(x) = prod_{i=0..15} (x + alpha^i), folded at elaboration.
   function automatic logic [7:0] gen_coef(input int idx);
      logic [7:0] g [0:16];
      logic [7:0] root;
      for (int j = 0; j <= 16; j++) g[j] = 8'h00;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = 16; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
         g[0] = gf_mul(g[0], root);
         root = gf_mul(root, 8'h02);
      end
      return g[idx];
   endfunction

   state_t     state_q;
   logic [7:0] cnt_q;
   logic [7:0] lfsr_q [N_PAR];
   logic [7:0] out_q;
   logic       out_valid_q;
   logic       out_sop_q;
   logic       out_eop_q;
   logic       in_ready_q;
   logic [15:0] pkt_cnt_q;

   logic       xfer;
   logic [7:0] fb;
   logic [7:0] tap        [N_PAR];
   logic [7:0] lfsr_feed  [N_PAR];
   logic [7:0] lfsr_shift [N_PAR];

   assign xfer = enc_if.in_valid & in_ready_q;
   assign fb   = enc_if.in ^ lfsr_q[N_PAR-1];

   for (genvar i = 0; i < N_PAR; i++) begin : g_tap
      localparam logic [7:0] COEF = gen_coef(i);
      assign tap[i] = gf_mul(fb, COEF);
   end

   always_comb begin
      lfsr_feed[0]  = tap[0];
      lfsr_shift[0] = 8'h00;
      for (int i = 1; i < N_PAR; i++) begin
         lfsr_feed[i]  = lfsr_q[i-1] ^ tap[i];
         lfsr_shift[i] = lfsr_q[i-1];
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         lfsr_q      <= '{default: 8'h00};
         out_q       <= 8'h00;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         pkt_cnt_q   <= 16'd0;
      end else begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         case (state_q)
            IDLE, DATA: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  lfsr_q      <= lfsr_feed;
                  out_q       <= enc_if.in;
                  out_valid_q <= 1'b1;
                  out_sop_q   <= (state_q == IDLE);
                  cnt_q       <= cnt_q + 8'd1;
                  if (cnt_q == LAST_DATA) begin
                     state_q    <= PARITY;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            PARITY: begin
               // Zero feedback drains r15..r0 in order and leaves the LFSR cleared.
               out_q       <= lfsr_q[N_PAR-1];
               out_valid_q <= 1'b1;
               lfsr_q      <= lfsr_shift;
               if (cnt_q == LAST_PAR) begin
                  state_q    <= IDLE;
                  cnt_q      <= 8'd0;
                  in_ready_q <= 1'b1;
                  out_eop_q  <= 1'b1;
                  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q    <= IDLE;
               cnt_q      <= 8'd0;
               lfsr_q     <= '{default: 8'h00};
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign enc_if.in_ready  = in_ready_q;
   assign enc_if.out       = out_q;
   assign enc_if.out_valid = out_valid_q;
   assign enc_if.out_sop   = out_sop_q;
   assign enc_if.out_eop   = out_eop_q;
   assign dbg_state_o      = state_q;

`ifdef RS_ENC_PKT_CNT_EN
   assign pkt_cnt = pkt_cnt_q;
`else
   logic unused_pkt_cnt;
   assign unused_pkt_cnt = ^pkt_cnt_q;
`endif

endmodule

// File: tb/tb_rs_encoder_204_188.sv
// Bench for rs_encoder_204_188: impulse-vector table plus reference long-division codewords.
module tb_rs_encoder_204_188;

   logic       Clk;
   logic       Reset;
   logic [1:0] dbg_state;
`ifdef RS_ENC_PKT_CNT_EN
   logic [15:0] pkt_cnt;
   logic [15:0] exp_pkt;
`endif

   rs_encoder_204_188_if bus ();

   rs_encoder_204_188 dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .enc_if      (bus),
`ifdef RS_ENC_PKT_CNT_EN
      .pkt_cnt     (pkt_cnt),
`endif
      .dbg_state_o (dbg_state)
   );

   typedef struct packed {
      logic [7:0]   last_byte;
      logic [7:0]   gap_pct;
      logic [127:0] par;
   } vec_t;

   vec_t       vecs [4];
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [9:0] exp_q [$];
   logic [7:0] gf_exp [512];
   logic [7:0] gf_log [256];
   logic [7:0] gpoly [17];
   logic [7:0] pkt_data [188];
   logic [7:0] pkt_par [16];
   int         ready_low_run = 0;
   logic [9:0] mon_e;
   int         w;

   // ---------------- clock ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- field model (log/antilog tables) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return gf_exp[int'(gf_log[a]) + int'(gf_log[b])];
   endfunction

   task automatic build_field();
      logic [8:0] x;
      x = 9'h001;
      for (int i = 0; i < 512; i++) gf_exp[i] = 8'h00;
      for (int i = 0; i < 256; i++) gf_log[i] = 8'h00;
      for (int i = 0; i < 255; i++) begin
         gf_exp[i]       = x[7:0];
         gf_exp[i + 255] = x[7:0];
         gf_log[x[7:0]]  = 8'(i);
         x = x << 1;
         if (x[8]) x = x ^ 9'h11D;
      end
      for (int j = 0; j <= 16; j++) gpoly[j] = 8'h00;
      gpoly[0] = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = 16; j >= 0; j--) begin
            if (j == 0) gpoly[0] = gmul(gpoly[0], gf_exp[i]);
            else        gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], gf_exp[i]);
         end
      end
   endtask

   // Remainder of m(x)*x^16 by g(x), by polynomial long division.
   task automatic ref_parity();
      logic [7:0] cw [204];
      logic [7:0] c;
      for (int k = 0; k < 204; k++) cw[k] = 8'h00;
      for (int n = 0; n < 188; n++) cw[203 - n] = pkt_data[n];
      for (int k = 203; k >= 16; k--) begin
         c = cw[k];
         if (c != 8'h00)
            for (int j = 0; j <= 16; j++) cw[k - 16 + j] = cw[k - 16 + j] ^ gmul(c, gpoly[j]);
      end
      for (int p = 0; p < 16; p++) pkt_par[p] = cw[15 - p];
   endtask

   task automatic fill_random();
      for (int n = 0; n < 188; n++) pkt_data[n] = 8'($urandom_range(255, 0));
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] b, input int gap_pct, input logic sop,
                            output int waited);
      waited = 0;
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
         bus.in_valid = 1'b0;
         @(negedge Clk);
      end
      bus.in       = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 64) begin
         @(negedge Clk);
         waited++;
      end
      if (!bus.in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready still 0 after %0d cycles, want 1", waited);
         bus.in_valid = 1'b0;
      end else begin
         exp_q.push_back({sop, 1'b0, b});
         @(negedge Clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic send_packet(input int gap_pct, output int wait0);
      int wb;
      wait0 = 0;
      for (int n = 0; n < 188; n++) begin
         send_byte(pkt_data[n], (n == 0) ? 0 : gap_pct, (n == 0), wb);
         if (n == 0) wait0 = wb;
      end
      for (int p = 0; p < 16; p++) exp_q.push_back({1'b0, (p == 15), pkt_par[p]});
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge Clk);
         k++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out"},       bus.out,       8'h00);
      check({tag, "_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "_out_sop"},   bus.out_sop,   1'b0);
      check({tag, "_out_eop"},   bus.out_eop,   1'b0);
      check({tag, "_in_ready"},  bus.in_ready,  1'b0);
      check({tag, "_state"},     dbg_state,     2'd0);
`ifdef RS_ENC_PKT_CNT_EN
      check({tag, "_pkt_cnt"},   pkt_cnt,       16'd0);
`endif
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge Clk) begin
      if (!Reset) begin
         ready_low_run = 0;
`ifdef RS_ENC_PKT_CNT_EN
         exp_pkt = 16'd0;
`endif
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL spurious_out: got byte 0x%02h sop=%0b eop=%0b, want out_valid=0",
                        bus.out, bus.out_sop, bus.out_eop);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_sop_eop_byte", {bus.out_sop, bus.out_eop, bus.out}, mon_e);
`ifdef RS_ENC_PKT_CNT_EN
               if (mon_e[8]) begin
                  exp_pkt = exp_pkt + 16'd1;
                  check("pkt_cnt", pkt_cnt, exp_pkt);
               end
`endif
            end
         end
         if (!bus.in_ready) ready_low_run++;
         else begin
            if (ready_low_run > 0) check("ready_low_len", ready_low_run, 16);
            ready_low_run = 0;
         end
      end
   end

   // ---------------- test ----------------
   initial begin
      Reset        = 1'b0;
      bus.in       = 8'h00;
      bus.in_valid = 1'b0;
`ifdef RS_ENC_PKT_CNT_EN
      exp_pkt      = 16'd0;
`endif
      build_field();

      // Impulse table: last data byte only; parity of 0x01 is g15..g0, others scale by the byte.
      for (int v = 0; v < 4; v++) vecs[v] = '0;
      vecs[0].last_byte = 8'h00;  vecs[0].gap_pct = 8'd0;
      vecs[1].last_byte = 8'h01;  vecs[1].gap_pct = 8'd0;
      vecs[2].last_byte = 8'h02;  vecs[2].gap_pct = 8'd30;
      vecs[3].last_byte = 8'h80;  vecs[3].gap_pct = 8'd10;
      for (int p = 0; p < 16; p++) begin
         vecs[1].par[p*8 +: 8] = gpoly[15 - p];
         vecs[2].par[p*8 +: 8] = gmul(8'h02, gpoly[15 - p]);
         vecs[3].par[p*8 +: 8] = gmul(8'h80, gpoly[15 - p]);
      end

      repeat (3) @(negedge Clk);
      check_reset_outputs("por");
      #2 Reset = 1'b1;
      @(negedge Clk);
      check("ready_after_reset", bus.in_ready, 1'b1);

      for (int v = 0; v < 4; v++) begin
         for (int n = 0; n < 188; n++) pkt_data[n] = 8'h00;
         pkt_data[187] = vecs[v].last_byte;
         for (int p = 0; p < 16; p++) pkt_par[p] = vecs[v].par[p*8 +: 8];
         send_packet(int'(vecs[v].gap_pct), w);
      end
      drain();

      // Random payload with gaps, then a back-to-back packet held valid through PARITY.
      fill_random();
      ref_parity();
      send_packet(30, w);
      fill_random();
      ref_parity();
      send_packet(0, w);
      check("idle_first_accept_wait", w, 16);
      drain();

      // Abort after byte 100, asynchronous reset between edges.
      fill_random();
      for (int n = 0; n <= 100; n++) send_byte(pkt_data[n], 0, (n == 0), w);
      drain();
      #2 Reset = 1'b0;
      #1 check_reset_outputs("abort_data");
      @(negedge Clk);
      @(negedge Clk);
      #2 Reset = 1'b1;
      @(negedge Clk);
      fill_random();
      ref_parity();
      send_packet(20, w);
      drain();

      // Abort in the middle of the parity burst.
      fill_random();
      ref_parity();
      send_packet(0, w);
      repeat (5) @(negedge Clk);
      #2 Reset = 1'b0;
      exp_q.delete();
      #1 check_reset_outputs("abort_parity");
      @(negedge Clk);
      @(negedge Clk);
      #2 Reset = 1'b1;
      @(negedge Clk);
      fill_random();
      ref_parity();
      send_packet(10, w);
      drain();

      repeat (4) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_encoder_204_188.md
RS_ENCODER_204_188 -- requirements
Module: rs_encoder_204_188

Interface
REQ-001 SHALL have parameter N_DATA, default 188, meaning data bytes per packet.
REQ-002 SHALL have parameter N_PAR, default 16, meaning parity bytes per packet; 2t with t=8; fixed, not overridable.
REQ-003 SHALL have port Clk, input, 1, the single system clock; all state on rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset; Reset=0 clears all state immediately.
REQ-005 SHALL have port in, input, 8, data byte.
REQ-006 SHALL have port in_valid, input, 1, in carries a valid byte.
REQ-007 SHALL have port in_ready, output, 1, encoder accepts a byte this cycle.
REQ-008 SHALL have port out, output, 8, encoded byte, registered.
REQ-009 SHALL have port out_valid, output, 1, out carries a valid byte.
REQ-010 SHALL have port out_sop, output, 1, out is byte 0 of a 204-byte codeword.
REQ-011 SHALL have port out_eop, output, 1, out is byte 203 of a codeword.

Function
REQ-012 SHALL implement systematic shortened RS(204,188) over GF(2^8), field polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02.
REQ-013 SHALL use generator g(x)=prod_{i=0..15}(x+alpha^i), realised as a 16-stage LFSR of 8-bit registers r0..r15 with constant GF multipliers.
REQ-014 SHALL accept a byte when in_valid and in_ready are both 1 (transfer), and only then.
REQ-015 SHALL run FSM states IDLE, DATA, PARITY.
REQ-016 IDLE: in_ready=1, LFSR cleared; first transfer loads byte 0 and moves to DATA with byte counter=1.
REQ-017 DATA: in_ready=1; each transfer feeds fb=in XOR r15 into the LFSR and increments the counter; transfer of byte 187 moves to PARITY.
REQ-018 PARITY: in_ready=0 for exactly 16 cycles; each cycle outputs r15 and shifts the LFSR with zero feedback; after the 16th cycle returns to IDLE with LFSR cleared.
REQ-019 SHALL output each data byte unchanged exactly 1 cycle after its transfer, with out_valid=1.
REQ-020 The first parity byte SHALL follow the last data byte on the next cycle; parity order SHALL be r15 first, r0 last.
REQ-021 out_sop SHALL be 1 with data byte 0; out_eop SHALL be 1 with the 16th parity byte; both SHALL be 0 otherwise.
REQ-022 Gaps (in_valid=0) in IDLE or DATA SHALL hold LFSR and counter, and SHALL give out_valid=0 on the following cycle.
REQ-023 out SHALL hold its last value when out_valid=0.
REQ-024 The byte counter SHALL be 8 bits and SHALL never exceed 203; no partial packet SHALL be flushed.

Reset
REQ-025 Reset=0 SHALL force state IDLE, counter=0, r0..r15=0, out=0x00, out_valid=0, out_sop=0, out_eop=0, in_ready=0.
REQ-026 in_ready SHALL become 1 on the first Clk edge after Reset deasserts.
REQ-027 Reset asserted mid-packet or mid-parity SHALL abandon the packet; the next packet SHALL encode as if from power-up.

Configuration
REQ-028 Macro RS_ENC_PKT_CNT_EN, when defined, SHALL add output pkt_cnt[15:0], reset 0, incremented on each out_eop and wrapping 0xFFFF->0x0000.
REQ-029 Without RS_ENC_PKT_CNT_EN, pkt_cnt SHALL not exist and behaviour SHALL otherwise be identical.

Verification
REQ-030 188 bytes of 0x00 back-to-back -> 204 output bytes all 0x00; out_sop on first byte, out_eop on 204th; in_ready=0 for exactly 16 cycles.
REQ-031 Bytes 0..186=0x00, byte 187=0x01 -> parity bytes equal g15..g0 of g(x); bytes 187=0x02 -> each parity byte is the GF product of 0x02 and the previous result.
REQ-032 MATLAB-generated packet file read with $fscanf, in_valid randomly deasserted 30% -> output matches MATLAB rs encoder 204-byte codeword bit-exactly.
REQ-033 Reset pulled low after byte 100, then a fresh 188-byte packet -> no output from the aborted packet; fresh codeword matches reference.
REQ-034 in_valid=1 held during PARITY -> no byte consumed; next packet's byte 0 accepted on the first IDLE cycle.
REQ-035 With RS_ENC_PKT_CNT_EN, 3 packets -> pkt_cnt steps 0->1->2->3, each step on the out_eop cycle.
